rr_merge_sched: RTL
===================

# rr_merge_sched

N-way round-robin scheduler that shares one downstream elastic channel among N upstream requesters. Each cycle it grants at most one valid input token and registers it on `out_data`. It also emits the granted requester's index as a token on a separate `idx_data` channel, for downstream demux or reorder logic. It sits between parallel producers and a shared consumer, and provides the fair selection sequence that a fixed two-way arbiter lacks.

## Interface
Parameters:
- `W`, 8, payload width; every token is W+1 bits, where bit W is valid and bits W-1:0 are payload.
- `N`, 4, number of requesters, N ≥ 2 (need not be a power of two).
- `IW`, $clog2(N), index payload width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  N*(W+1)  flattened input tokens; requester i occupies bits [i*(W+1) +: W+1].
- `in_back_stop`  out  N  per-requester stop; 1 means the token is not taken this cycle.
- `out_data`  out  W+1  registered output token.
- `out_stop`  in  1  downstream stop for `out_data`.
- `idx_data`  out  IW+1  registered index token; bit IW is valid.
- `idx_stop`  in  1  downstream stop for `idx_data`.

## Operation
- A transfer on any channel occurs when valid=1 and stop=0 in the same cycle.
- Upstream holds a stalled token stable until it transfers.
- State is:
  - `ptr` (IW bits, range 0..N-1);
  - the output slot: `out_v` plus payload;
  - the index slot: `idx_v` plus index.
- Free conditions:
  - `out_free = !out_v | !out_stop`
  - `idx_free = !idx_v | !idx_stop`
  - `ready = out_free & idx_free`.
- Grant (combinational):
  - When `ready`=1, grant the first valid requester found by scanning ptr, ptr+1, …, wrapping modulo N.
  - When `ready`=0 or no input is valid, there is no grant.
- `in_back_stop[i]` = 0 only for the granted requester; all other bits are 1.
- On a grant to i:
  - the output slot loads in_data[i] (valid=1);
  - the index slot loads {1, i};
  - `ptr` ← (i+1) mod N.
  - For N not a power of two, the wrap is explicit (N=3: 2→0).
- No grant:
  - A slot whose token transferred this cycle clears its valid bit; payload is don't-care.
  - An untransferred slot holds its token.
  - `ptr` holds.
- The two output slots drain independently (fork semantics). Because a new grant requires `ready`, the two slots never hold tokens from different grants.
- Reset (`rst_n`=0), applied at any time, including mid-stall:
  - ptr=0, `out_data`=0, `idx_data`=0, all `in_back_stop`=1;
  - any held tokens are discarded.

## Timing
- Latency is 1 cycle: a token granted in cycle t appears on `out_data`/`idx_data` in cycle t+1.
- Throughput is 1 token/cycle with both stops low; a slot may reload in the same cycle it drains.
- `in_back_stop` is combinational from `in_data` valids, `ptr`, slot valids, `out_stop` and `idx_stop`. There is no combinational path from `in_data` payload.
- `out_data`, `idx_data` and `ptr` are driven directly from flops.
- After `rst_n` deasserts, the first grant can occur on the first rising edge.
- Simultaneous events:
  - Drain and reload of a slot in the same cycle: reload wins.
  - All N valid: grant order is strictly ptr, ptr+1, …
  - A requester whose token is its only valid one is granted every ready cycle.

## Test plan
- Single requester: requester 2 valid with payloads 0x11, 0x22, 0x33, both stops 0 → out 0x11/0x22/0x33 on consecutive cycles starting 1 cycle later; idx = 2 each time; `in_back_stop` = 4'b1011.
- Full contention: N=4, all valid continuously, stops 0 → idx sequence 0,1,2,3,0,1; each requester's payload appears in that order.
- Joint stall: `out_stop`=1 for 3 cycles while out_v=1 → out and idx hold; all `in_back_stop`=1; ptr is unchanged. Release → the held token transfers and the next grant loads in the same cycle.
- Asymmetric stall: `out_stop`=0, `idx_stop`=1 → out transfers and then goes invalid; idx holds; no new grant until `idx_stop` drops.
- Wrap with N=3: requesters 0 and 2 valid, ptr=1 → grant 2, then ptr=0 → grant 0, then 2.
- Reset mid-operation: assert `rst_n`=0 asynchronously with out_v=1 and stops high → out_data=0, idx_data=0 and all `in_back_stop`=1 immediately, ptr=0. After release, requester 1 is granted before requester 3 when both are valid.

Source files
------------

// File: rtl/rr_merge_sched.sv
// Round-robin merge of N elastic token streams onto one output slot, with the
// granted requester index forked onto a second independently-draining slot.
module rr_merge_sched #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*(W+1)-1:0] in_data,
    output logic [N-1:0]       in_back_stop,
    output logic [W:0]         out_data,
    input  logic               out_stop,
    output logic [IW:0]        idx_data,
    input  logic               idx_stop
);

    localparam int          NP    = 1 << IW;
    localparam logic [IW:0] N_EXT = (IW+1)'(N);

    logic [IW-1:0] ptr;
    logic [NP-1:0] req_vld_p0;
    logic          out_free_p0;
    logic          idx_free_p0;
    logic          ready_p0;
    logic          gnt_vld_p0;
    logic [IW-1:0] gnt_idx_p0;
    logic [IW-1:0] ptr_nxt_p0;
    logic [W:0]    gnt_tok_p0;
    logic [IW:0]   cand_p0;

    // Stage p0: combinational grant from request valids, pointer and slot state

    // Padded to a power of two so the rotating index never leaves the vector.
    always_comb begin
        req_vld_p0 = '0;
        for (int i = 0; i < N; i++) begin
            req_vld_p0[i] = in_data[i*(W+1)+W];
        end
    end

    assign out_free_p0 = !out_data[W] || !out_stop;
    assign idx_free_p0 = !idx_data[IW] || !idx_stop;
    assign ready_p0    = rst_n && out_free_p0 && idx_free_p0;

    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_idx_p0 = '0;
        cand_p0    = '0;
        for (int k = 0; k < N; k++) begin
            cand_p0 = {1'b0, ptr} + (IW+1)'(k);
            if (cand_p0 >= N_EXT) begin
                cand_p0 = cand_p0 - N_EXT;
            end
            if (ready_p0 && !gnt_vld_p0 && req_vld_p0[cand_p0[IW-1:0]]) begin
                gnt_vld_p0 = 1'b1;
                gnt_idx_p0 = cand_p0[IW-1:0];
            end
        end
    end

    // Stop bits depend only on the grant decision; the payload mux shares the select.
    always_comb begin
        in_back_stop = '1;
        gnt_tok_p0   = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_vld_p0 && (gnt_idx_p0 == IW'(i))) begin
                in_back_stop[i] = 1'b0;
                gnt_tok_p0      = in_data[i*(W+1) +: W+1];
            end
        end
    end

    assign ptr_nxt_p0 = (gnt_idx_p0 == IW'(N-1)) ? '0 : gnt_idx_p0 + 1'b1;

    // Stage p1: output and index slots, pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            out_data <= '0;
            idx_data <= '0;
        end else if (gnt_vld_p0) begin
            ptr      <= ptr_nxt_p0;
            out_data <= {1'b1, gnt_tok_p0[W-1:0]};
            idx_data <= {1'b1, gnt_idx_p0};
        end else begin
            if (!out_stop) begin
                out_data[W] <= 1'b0;
            end
            if (!idx_stop) begin
                idx_data[IW] <= 1'b0;
            end
        end
    end

endmodule
